// File: rtl/boot_pkg.sv
// Shared definitions for the SPI flash boot loader.
// Holds the boot FSM state type, the flash read command and the
// command/address bit counts. The ERROR state exists only when the
// image checksum check is built in (macro BOOT_CHECKSUM_EN).
package boot_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         CMD_BITS       = 8;
    localparam int         ADDR_BITS      = 24;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, WRITE, DONE, ERROR
    } boot_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, WRITE, DONE
    } boot_state_t;
`endif

    // Flash bytes arrive in order b0 b1 b2 b3, each MSB first, so the raw
    // shift register holds {b0,b1,b2,b3}; the RAM word is little-endian.
    function automatic logic [31:0] le_word(input logic [31:0] raw);
        return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_boot_loader_shift_engine.sv
// spi_shift_engine: SPI mode-0 clock divider plus a 32-bit transmit and
// receive shifter.
//   load     : restart the divider with sclk low and present tx_data[31]
//   en       : run sclk; when low, sclk and mosi are forced to 0
//   tx_data  : 32 bits sent MSB first, mosi updated on sclk falling edges
//   miso     : sampled in the cycle whose clock edge raises sclk
//   bit_done : one-cycle pulse in that sampling cycle
//   bit_cnt  : bits sampled since load, modulo 32
//   rx_word  : received word including the bit being sampled now
module spi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        bit_done,
    output logic [4:0]  bit_cnt,
    output logic [31:0] rx_word
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [30:0]      tx_shift;
    logic [30:0]      rx_shift;
    logic             tick;

    // Half-period timer: down-counter, sclk toggles at terminal count.
    assign tick     = en && (div_cnt == '0);
    assign bit_done = tick && !sclk;
    assign rx_word  = {rx_shift, miso};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            div_cnt  <= DIV_LOAD;
            sclk     <= 1'b0;
            mosi     <= tx_data[31];
            tx_shift <= tx_data[30:0];
            bit_cnt  <= '0;
        end else if (!en) begin
            div_cnt  <= DIV_LOAD;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            bit_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= DIV_LOAD;
            sclk    <= !sclk;
            if (!sclk) begin
                rx_shift <= rx_word[30:0];
                bit_cnt  <= bit_cnt + 5'd1;
            end else begin
                // Falling edge: next bit gets a full low half-period of setup.
                mosi     <= tx_shift[30];
                tx_shift <= {tx_shift[29:0], 1'b0};
            end
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_boot_loader.sv
// spi_flash_boot_loader: boot-time SPI master that streams IMG_WORDS
// 32-bit words from serial flash (read command 03 at FLASH_BASE) into the
// code RAM write port, holding the CPU in reset until the copy completes.
// Optional macro BOOT_CHECKSUM_EN: one trailing word is read and compared
// with the mod-2^32 sum of the image; a mismatch parks the FSM in ERROR.
// Ports:
//   clk, rst                    : system clock, async active-high reset
//   spi_sclk/cs_n/mosi/miso     : SPI mode-0 flash interface
//   mem_we/mem_addr/mem_wdata   : code RAM write port, one-cycle strobe
//   cpu_rst                     : core reset, released when boot completes
//   boot_sequence_done          : sticky boot-complete flag
//   boot_error                  : checksum failure (0 without the macro)
//
// state | meaning
// IDLE  | one cycle after reset, drops chip select and loads the header
// CMD   | shifting out the 8-bit read command
// ADDR  | shifting out the 24-bit flash byte address
// DATA  | receiving one 32-bit word
// WRITE | one cycle, RAM write strobe (or checksum capture) active
// DONE  | image loaded, CPU released, until reset
// ERROR | checksum mismatch, CPU held in reset (BOOT_CHECKSUM_EN only)
module spi_flash_boot_loader
    import boot_pkg::*;
#(
    parameter int          IMG_WORDS  = 4096,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 2,
    parameter int          ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              boot_sequence_done,
    output logic              boot_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WORDS - 1);
    localparam int                HDR_BITS  = CMD_BITS + ADDR_BITS;

    boot_state_t state;
    logic        eng_load;
    logic        eng_en;
    logic        bit_done;
    logic [4:0]  bit_cnt;
    logic [31:0] rx_word;
    logic        word_done;
    logic        last_word;
    logic        final_word;

    assign word_done = bit_done && (bit_cnt == 5'd31);
    assign last_word = (mem_addr == LAST_ADDR);

`ifdef BOOT_CHECKSUM_EN
    logic        csum_phase;
    logic [31:0] csum_acc;
    logic [31:0] csum_rx;
    logic        boot_error_q;

    assign final_word = csum_phase;
    assign boot_error = boot_error_q;
`else
    assign final_word = last_word;
    assign boot_error = 1'b0;
`endif

    // The engine keeps running through WRITE so the stream has no gaps;
    // it stops in the final WRITE so sclk falls as chip select rises.
    assign eng_load = (state == IDLE);
    assign eng_en   = (state == CMD) || (state == ADDR) || (state == DATA) ||
                      ((state == WRITE) && !final_word);

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (eng_load),
        .en       (eng_en),
        .tx_data  ({FLASH_CMD_READ, FLASH_BASE}),
        .miso     (spi_miso),
        .sclk     (spi_sclk),
        .mosi     (spi_mosi),
        .bit_done (bit_done),
        .bit_cnt  (bit_cnt),
        .rx_word  (rx_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            spi_cs_n           <= 1'b1;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            cpu_rst            <= 1'b1;
            boot_sequence_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_phase         <= 1'b0;
            csum_acc           <= '0;
            csum_rx            <= '0;
            boot_error_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    spi_cs_n <= 1'b0;
                    state    <= CMD;
                end
                CMD: begin
                    if (bit_done && (bit_cnt == 5'(CMD_BITS - 1))) state <= ADDR;
                end
                ADDR: begin
                    if (bit_done && (bit_cnt == 5'(HDR_BITS - 1))) state <= DATA;
                end
                DATA: begin
                    if (word_done) begin
                        state <= WRITE;
`ifdef BOOT_CHECKSUM_EN
                        if (csum_phase) begin
                            csum_rx <= le_word(rx_word);
                        end else begin
                            mem_we    <= 1'b1;
                            mem_wdata <= le_word(rx_word);
                            csum_acc  <= csum_acc + le_word(rx_word);
                        end
`else
                        mem_we    <= 1'b1;
                        mem_wdata <= le_word(rx_word);
`endif
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (final_word) begin
                        spi_cs_n <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        state <= (csum_acc == csum_rx) ? DONE : ERROR;
`else
                        state <= DONE;
`endif
                    end else begin
                        state <= DATA;
`ifdef BOOT_CHECKSUM_EN
                        // Address stays at the last word while the checksum word streams in.
                        if (last_word) csum_phase <= 1'b1;
                        else           mem_addr   <= mem_addr + ADDR_W'(1);
`else
                        mem_addr <= mem_addr + ADDR_W'(1);
`endif
                    end
                end
                DONE: begin
                    cpu_rst            <= 1'b0;
                    boot_sequence_done <= 1'b1;
                end
`ifdef BOOT_CHECKSUM_EN
                ERROR: begin
                    boot_error_q <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
module tb_spi_flash_boot_loader;

    localparam int IMG = 4;
`ifdef BOOT_CHECKSUM_EN
    localparam int NW = IMG + 1;
`else
    localparam int NW = IMG;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst = 3'b111;
    logic [2:0]  miso = 3'b000;
    logic [2:0]  sclk, cs_n, mosi, we, cpu_rst, done, err;
    logic [11:0] addr [3];
    logic [31:0] wdata [3];

    // Instance 0: CLK_DIV=2, base 0. Instance 1: CLK_DIV=1. Instance 2: CLK_DIV=3, base 010000.
    spi_flash_boot_loader #(.IMG_WORDS(IMG), .FLASH_BASE(24'h000000), .CLK_DIV(2), .ADDR_W(12)) u_d2 (
        .clk(clk), .rst(rst[0]), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .cpu_rst(cpu_rst[0]), .boot_sequence_done(done[0]), .boot_error(err[0]));
    spi_flash_boot_loader #(.IMG_WORDS(IMG), .FLASH_BASE(24'h000000), .CLK_DIV(1), .ADDR_W(12)) u_d1 (
        .clk(clk), .rst(rst[1]), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .cpu_rst(cpu_rst[1]), .boot_sequence_done(done[1]), .boot_error(err[1]));
    spi_flash_boot_loader #(.IMG_WORDS(IMG), .FLASH_BASE(24'h010000), .CLK_DIV(3), .ADDR_W(12)) u_d3 (
        .clk(clk), .rst(rst[2]), .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .cpu_rst(cpu_rst[2]), .boot_sequence_done(done[2]), .boot_error(err[2]));

    int errors = 0;
    int checks = 0;

    // Flash contents per instance and the reference expectations.
    logic [7:0]  img [3][20];
    logic [31:0] exp_w [3][IMG];
    logic [31:0] img_sum [3];
    logic [31:0] cword [3];
    logic        exp_err [3];
    int          cdv [3];
    logic [23:0] fbv [3];

    // Observations gathered by the flash model / bus monitor.
    int          cyc = 0;
    int          rises [3], last_rise [3], per_min [3], per_max [3];
    int          setup_min [3], last_chg [3], mosi_bad [3];
    int          cs_rise_cyc [3], done_cyc [3], cpurst_cyc [3], err_cyc [3];
    int          obs_n [3], we_after [3], chg_after [3];
    logic [31:0] cmd [3];
    logic [11:0] obs_a [3][8];
    logic [31:0] obs_d [3][8];
    logic [2:0]  p_sclk, p_cs, p_mosi, p_done, p_cpu, p_err;
    logic        noise = 1'b0;

    function automatic logic flash_bit(input int g, input int r);
        int k;
        int j;
        logic [7:0] b;
        if (r < 32) return 1'($urandom_range(0, 1));
        k = r - 32;
        j = k / 8;
        if (j >= 20) return 1'($urandom_range(0, 1));
        b = img[g][j];
        return b[7 - (k % 8)];
    endfunction

    // Flash model and bus monitor; everything sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) begin
                rises[g] = 0; obs_n[g] = 0; cmd[g] = '0; last_rise[g] = -1;
                per_min[g] = 1 << 30; per_max[g] = 0; setup_min[g] = 1 << 30;
                mosi_bad[g] = 0; last_chg[g] = cyc;
                cs_rise_cyc[g] = -1; done_cyc[g] = -1; cpurst_cyc[g] = -1; err_cyc[g] = -1;
            end else begin
                if (p_cs[g] && !cs_n[g]) begin
                    rises[g] = 0; cmd[g] = '0; last_rise[g] = -1; last_chg[g] = cyc;
                    miso[g] = flash_bit(g, 0);
                end
                if (!p_cs[g] && cs_n[g]) cs_rise_cyc[g] = cyc;
                if (mosi[g] != p_mosi[g]) begin
                    last_chg[g] = cyc;
                    if (sclk[g]) mosi_bad[g]++;
                end
                if (!p_sclk[g] && sclk[g]) begin
                    if (rises[g] < 32) cmd[g] = {cmd[g][30:0], mosi[g]};
                    if (cyc - last_chg[g] < setup_min[g]) setup_min[g] = cyc - last_chg[g];
                    if (last_rise[g] >= 0) begin
                        if (cyc - last_rise[g] < per_min[g]) per_min[g] = cyc - last_rise[g];
                        if (cyc - last_rise[g] > per_max[g]) per_max[g] = cyc - last_rise[g];
                    end
                    last_rise[g] = cyc;
                    rises[g]++;
                end
                if (p_sclk[g] && !sclk[g] && !cs_n[g]) miso[g] = flash_bit(g, rises[g]);
                if (we[g]) begin
                    if (obs_n[g] < 8) begin
                        obs_a[g][obs_n[g]] = addr[g];
                        obs_d[g][obs_n[g]] = wdata[g];
                    end
                    obs_n[g]++;
                end
                if (!p_done[g] && done[g]) done_cyc[g] = cyc;
                if (p_cpu[g] && !cpu_rst[g]) cpurst_cyc[g] = cyc;
                if (!p_err[g] && err[g]) err_cyc[g] = cyc;
                if (noise) begin
                    miso[g] = 1'($urandom_range(0, 1));
                    if (we[g]) we_after[g]++;
                    if ({sclk[g], cs_n[g], mosi[g], cpu_rst[g], done[g], err[g]} !=
                        {p_sclk[g], p_cs[g], p_mosi[g], p_cpu[g], p_done[g], p_err[g]})
                        chg_after[g]++;
                end
            end
            p_sclk[g] = sclk[g]; p_cs[g] = cs_n[g]; p_mosi[g] = mosi[g];
            p_done[g] = done[g]; p_cpu[g] = cpu_rst[g]; p_err[g] = err[g];
        end
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [11:0] snap_a [3];
    logic [31:0] snap_d [3];
    int          t;

    initial begin
        cdv = '{2, 1, 3};
        fbv = '{24'h000000, 24'h000000, 24'h010000};

        // Image: instance 0 uses bytes 01..10, the others random bytes.
        for (int g = 0; g < 3; g++)
            for (int j = 0; j < 16; j++)
                img[g][j] = (g == 0) ? 8'(j + 1) : 8'($urandom);
        for (int g = 0; g < 3; g++) begin
            img_sum[g] = '0;
            for (int i = 0; i < IMG; i++) begin
                exp_w[g][i] = {img[g][4*i+3], img[g][4*i+2], img[g][4*i+1], img[g][4*i]};
                img_sum[g] = img_sum[g] + exp_w[g][i];
            end
            // Trailing word: correct sum for instances 0 and 2, zero for instance 1.
            cword[g] = (g == 1) ? 32'h0 : img_sum[g];
            for (int b = 0; b < 4; b++) img[g][16+b] = cword[g][8*b +: 8];
            exp_err[g] = (NW > IMG) && (img_sum[g] != cword[g]);
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++)
            chk($sformatf("reset_outputs_%0d", g),
                {sclk[g], cs_n[g], mosi[g], we[g], cpu_rst[g], done[g], err[g], addr[g], wdata[g]},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0});

        rst = 3'b000;

        // Abort instance 0 while word 2 is streaming in.
        t = 0;
        while (t < 20000 && obs_n[0] < 2) begin
            @(negedge clk);
            t++;
        end
        chk("reach_word2", 64'(obs_n[0] >= 2), 64'd1);
        repeat (20) @(negedge clk);
        chk("mid_transfer_cs", 64'(cs_n[0]), 64'd0);
        #2 rst[0] = 1'b1;
        #1;
        chk("abort_outputs", {sclk[0], cs_n[0], mosi[0], we[0], cpu_rst[0], done[0]},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        repeat (4) @(negedge clk);
        rst[0] = 1'b0;

        t = 0;
        while (t < 20000 && !(&(done | err))) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("complete_%0d", g), 64'(done[g] | err[g]), 64'd1);
            chk($sformatf("cmd_addr_%0d", g), 64'(cmd[g]), 64'({8'h03, fbv[g]}));
            chk($sformatf("write_count_%0d", g), 64'(obs_n[g]), 64'(IMG));
            for (int i = 0; i < IMG; i++)
                chk($sformatf("write_%0d_%0d", g, i), {obs_a[g][i], obs_d[g][i]},
                    {12'(i), exp_w[g][i]});
            chk($sformatf("sclk_rises_%0d", g), 64'(rises[g]), 64'(32 + 32 * NW));
            chk($sformatf("period_min_%0d", g), 64'(per_min[g]), 64'(2 * cdv[g]));
            chk($sformatf("period_max_%0d", g), 64'(per_max[g]), 64'(2 * cdv[g]));
            chk($sformatf("mosi_setup_%0d", g), 64'(setup_min[g]), 64'(cdv[g]));
            chk($sformatf("mosi_high_chg_%0d", g), 64'(mosi_bad[g]), 64'd0);
            chk($sformatf("final_addr_%0d", g), 64'(addr[g]), 64'(IMG - 1));
            chk($sformatf("status_%0d", g), {done[g], cpu_rst[g], err[g], cs_n[g], sclk[g], mosi[g]},
                {!exp_err[g], exp_err[g], exp_err[g], 1'b1, 1'b0, 1'b0});
            if (!exp_err[g]) begin
                chk($sformatf("done_after_cs_%0d", g), 64'(done_cyc[g] - cs_rise_cyc[g]), 64'd1);
                chk($sformatf("cpu_rst_with_done_%0d", g), 64'(cpurst_cyc[g]), 64'(done_cyc[g]));
            end else begin
                chk($sformatf("error_after_cs_%0d", g), 64'(err_cyc[g] - cs_rise_cyc[g]), 64'd1);
            end
        end

        // Random miso after completion must not disturb anything.
        for (int g = 0; g < 3; g++) begin
            snap_a[g] = addr[g];
            snap_d[g] = wdata[g];
        end
        noise = 1'b1;
        repeat (1000) @(negedge clk);
        noise = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("quiet_we_%0d", g), 64'(we_after[g]), 64'd0);
            chk($sformatf("quiet_outputs_%0d", g), 64'(chg_after[g]), 64'd0);
            chk($sformatf("quiet_bus_%0d", g), {addr[g], wdata[g]}, {snap_a[g], snap_d[g]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
